// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared types and constants for the sync_fifo read-side controller.
//   state_e     : reader FSM encoding (IDLE / STREAM / FLUSH)
//   SKID_DEPTH  : number of entries in the output skid buffer
//   credit_occ  : words owned by the reader after this cycle's pop
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  localparam int unsigned SKID_DEPTH = 2;

  // Buffered words plus the word in flight, minus the word leaving this cycle.
  // A pop implies buf_cnt >= 1, so the subtraction cannot wrap.
  function automatic logic [2:0] credit_occ(input logic [1:0] buf_cnt,
                                            input logic       inflight,
                                            input logic       pop);
    credit_occ = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/sync_fifo_reader_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_reader_if
// Bundles the FIFO read port and the downstream valid/ready stream.
//   fifo_rd_en     : pop request to the FIFO
//   fifo_rd_data   : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty     : FIFO empty flag
//   fifo_underflow : FIFO underflow indication
//   m_valid/m_data : stream payload towards the consumer
//   m_ready        : consumer accept
// Modports: master = the reader, slave = FIFO + consumer side.
// -----------------------------------------------------------------------------
interface sync_fifo_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  fifo_underflow;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_empty,
    input  fifo_underflow,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_empty,
    output fifo_underflow,
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/skid_buf2.sv
// -----------------------------------------------------------------------------
// skid_buf2
// Two-entry skid buffer; slot0 is the head presented downstream.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : drop all held words (count -> 0)
//   push      : write push_data (returning FIFO word)
//   pop       : head consumed this cycle
//   count     : number of valid entries (0..2)
//   head      : slot0 contents
// The caller guarantees no push when full without a pop, and no pop when empty.
// -----------------------------------------------------------------------------
module skid_buf2
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [1:0]            cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;

  // Next-state of the buffer: clear wins, then push/pop combinations.
  always_comb begin
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (clear) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          // Plain return: the word lands in slot[count].
          if (cnt_q == 2'd0) begin
            slot0_d = push_data;
            cnt_d   = 2'd1;
          end else if (cnt_q == 2'd1) begin
            slot1_d = push_data;
            cnt_d   = 2'(SKID_DEPTH);
          end else begin
            cnt_d = cnt_q;
          end
        end
        2'b01: begin
          slot0_d = slot1_q;
          if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end
        2'b11: begin
          // Pop and return together: occupancy unchanged, queue shifts forward.
          if (cnt_q == 2'(SKID_DEPTH)) begin
            slot0_d = slot1_q;
            slot1_d = push_data;
          end else begin
            slot0_d = push_data;
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // Buffer storage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      slot0_q <= {DATA_WIDTH{1'b0}};
      slot1_q <= {DATA_WIDTH{1'b0}};
    end else begin
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign count = cnt_q;
  assign head  = slot0_q;

endmodule

// File: rtl/sync_fifo_reader.sv
// -----------------------------------------------------------------------------
// sync_fifo_reader
// Read-side controller for sync_fifo. Issues pops, absorbs the FIFO's one-cycle
// read latency in a 2-entry skid buffer and streams one word per cycle.
//   clk, rst       : clock, synchronous active-high reset
//   bus (master)   : FIFO read port + valid/ready output stream
//   flush          : discard held and in-flight words
//   busy           : buffer non-empty, read in flight, or flushing
//   err_underflow  : sticky FIFO underflow flag, cleared on flush entry or rst
//   rd_count       : delivered-word counter (only with SYNC_FIFO_READER_STATS_EN)
// Optional feature macro: SYNC_FIFO_READER_STATS_EN.
// -----------------------------------------------------------------------------
module sync_fifo_reader
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sync_fifo_reader_if.master   bus,
  input  logic                 flush,
  output logic                 busy,
  output logic                 err_underflow
`ifdef SYNC_FIFO_READER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] rd_count
`endif
);

  if (CNT_WIDTH < 1) begin : g_cnt_width_check
    $error("CNT_WIDTH must be at least 1");
  end

  state_e                state_q,    state_d;
  logic                  inflight_q, inflight_d;
  logic                  err_q,      err_d;

  logic [1:0]            buf_cnt_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  clear_s;
  logic                  rd_en_s;

  assign pop_s = (buf_cnt_s != 2'd0) && bus.m_ready;

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          state_d = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (flush) begin
          state_d = FLUSH;
        end else begin
          state_d = STREAM;
        end
      end
      FLUSH: begin
        // Wait for any outstanding word to come back so it can be dropped.
        if (!flush && !inflight_q) begin
          state_d = STREAM;
        end else begin
          state_d = FLUSH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Credit-based pop request, buffer control and sticky error.
  always_comb begin
    rd_en_s    = 1'b0;
    clear_s    = 1'b0;
    push_s     = 1'b0;
    inflight_d = 1'b0;
    err_d      = err_q;
    // Never request a word that would not fit once it returns.
    if ((state_q == STREAM) && !bus.fifo_empty &&
        (credit_occ(buf_cnt_s, inflight_q, pop_s) < 3'(SKID_DEPTH))) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    // Entering FLUSH empties the buffer; returns while not streaming are dropped.
    clear_s    = (state_q == STREAM) && flush;
    push_s     = inflight_q && (state_q == STREAM);
    inflight_d = rd_en_s;
    if (clear_s) begin
      err_d = 1'b0;
    end else if (bus.fifo_underflow) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_s),
    .push      (push_s),
    .push_data (bus.fifo_rd_data),
    .pop       (pop_s),
    .count     (buf_cnt_s),
    .head      (head_s)
  );

  assign bus.fifo_rd_en = rd_en_s;
  assign bus.m_valid    = (buf_cnt_s != 2'd0);
  assign bus.m_data     = head_s;
  assign busy           = (buf_cnt_s != 2'd0) || inflight_q || (state_q == FLUSH);
  assign err_underflow  = err_q;

`ifdef SYNC_FIFO_READER_STATS_EN
  logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;

  // Delivered-word counter; wraps naturally and survives flush.
  always_comb begin
    if (pop_s) begin
      rd_count_d = rd_count_q + CNT_WIDTH'(1);
    end else begin
      rd_count_d = rd_count_q;
    end
  end

  // Counter register, cleared by rst only.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count_q <= {CNT_WIDTH{1'b0}};
    end else begin
      rd_count_q <= rd_count_d;
    end
  end

  assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_reader
// Directed bench for sync_fifo_reader. A small FIFO model feeds the read port;
// every word loaded is also pushed to an expected queue that a negedge monitor
// pops and compares whenever the stream transfers a word.
// -----------------------------------------------------------------------------
module tb_sync_fifo_reader;
  import sync_fifo_pkg::*;

  localparam int DW = 8;
`ifdef SYNC_FIFO_READER_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;
  logic err_underflow;
`ifdef SYNC_FIFO_READER_STATS_EN
  logic [CW-1:0] rd_count;
`endif

  sync_fifo_reader_if #(.DATA_WIDTH(DW)) bus ();

  sync_fifo_reader #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.master),
    .flush         (flush),
    .busy          (busy),
    .err_underflow (err_underflow)
`ifdef SYNC_FIFO_READER_STATS_EN
    ,
    .rd_count      (rd_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- FIFO model ----------------
  logic [DW-1:0] stim_mem [0:255];
  int            stim_wr = 0;
  int            stim_rd = 0;
  logic          fifo_drop;
  logic          pop_req = 1'b0;
  logic [DW-1:0] exp_q [$];

  assign bus.fifo_empty = (stim_rd == stim_wr);

  always @(negedge clk) pop_req <= bus.fifo_rd_en;

  always @(posedge clk) begin
    if (fifo_drop) begin
      stim_rd <= stim_wr;
    end else if (pop_req && (stim_rd != stim_wr)) begin
      bus.fifo_rd_data <= stim_mem[stim_rd];
      stim_rd          <= stim_rd + 1;
    end
  end

  task automatic load(input logic [DW-1:0] w);
    stim_mem[stim_wr] = w;
    stim_wr++;
    exp_q.push_back(w);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic credit_en = 1'b0;
  int   occ = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL stream_extra: got 0x%0h, expected no word at %0t", bus.m_data, $time);
        end else begin
          chk("stream_data", {24'd0, bus.m_data}, {24'd0, exp_q.pop_front()});
        end
      end
      if (bus.fifo_rd_en) begin
        chk("no_pop_when_empty", {31'd0, bus.fifo_empty}, 32'd0);
      end
      if (credit_en) begin
        occ = occ + (bus.fifo_rd_en ? 1 : 0) - ((bus.m_valid && bus.m_ready) ? 1 : 0);
        if (bus.fifo_rd_en) begin
          chk("credit_bound", {31'd0, (occ <= 2)}, 32'd1);
        end
      end else begin
        occ = 0;
      end
    end
  end

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (((exp_q.size() != 0) || busy) && (n < max_cyc)) begin
      step();
      n++;
    end
    chk(name, {31'd0, (n < max_cyc)}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst                = 1'b1;
    flush              = 1'b0;
    fifo_drop          = 1'b0;
    bus.m_ready        = 1'b0;
    bus.fifo_underflow = 1'b0;
    step();
    step();

    // Reset values
    chk("rst_rd_en",   {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("rst_m_valid", {31'd0, bus.m_valid},    32'd0);
    chk("rst_m_data",  {24'd0, bus.m_data},     32'd0);
    chk("rst_busy",    {31'd0, busy},           32'd0);
    chk("rst_err",     {31'd0, err_underflow},  32'd0);

    // Preloaded burst at full throughput
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    bus.m_ready = 1'b1;
    rst = 1'b0;
    step();                                   // STREAM entered
    chk("s1_first_rd_en", {31'd0, bus.fifo_rd_en}, 32'd1);
    chk("s1_no_valid_c1", {31'd0, bus.m_valid},    32'd0);
    step();
    chk("s1_no_valid_c2", {31'd0, bus.m_valid},    32'd0);
    step();
    chk("s1_valid_w0", {31'd0, bus.m_valid}, 32'd1);
    chk("s1_data_w0",  {24'd0, bus.m_data},  32'h11);
    step();
    chk("s1_data_w1",  {24'd0, bus.m_data},  32'h22);
    step();
    chk("s1_data_w2",  {24'd0, bus.m_data},  32'h33);
    step();
    chk("s1_data_w3",  {24'd0, bus.m_data},  32'h44);
    chk("s1_busy_last", {31'd0, busy},       32'd1);
    step();
    chk("s1_valid_end", {31'd0, bus.m_valid}, 32'd0);
    chk("s1_busy_end",  {31'd0, busy},        32'd0);

    // Downstream stall: only two words may be pulled
    bus.m_ready = 1'b0;
    load(8'h11); load(8'h22); load(8'h33); load(8'h44); load(8'h55);
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i >= 2) begin
        chk("s2_hold_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("s2_hold_data",  {24'd0, bus.m_data},  32'h11);
      end
    end
    chk("s2_fifo_left", stim_wr - stim_rd,         32'd3);
    chk("s2_rd_en_full", {31'd0, bus.fifo_rd_en},  32'd0);
    bus.m_ready = 1'b1;
    step();
    chk("s2_data_a", {24'd0, bus.m_data}, 32'h22);
    step();
    chk("s2_data_b", {24'd0, bus.m_data}, 32'h33);
    chk("s2_valid_b", {31'd0, bus.m_valid}, 32'd1);
    step();
    chk("s2_data_c", {24'd0, bus.m_data}, 32'h44);
    step();
    chk("s2_data_d", {24'd0, bus.m_data}, 32'h55);
    step();
    chk("s2_valid_end", {31'd0, bus.m_valid}, 32'd0);

    // Alternating m_ready over 8 words
    credit_en = 1'b1;
    for (int i = 0; i < 8; i++) load(8'hA0 + 8'(i));
    begin
      int n;
      n = 0;
      while (((exp_q.size() != 0) || busy) && (n < 80)) begin
        bus.m_ready = ~bus.m_ready;
        step();
        n++;
      end
      chk("s3_drain", {31'd0, (n < 80)}, 32'd1);
    end
    credit_en   = 1'b0;
    bus.m_ready = 1'b1;
    step();

    // Flush with one word buffered and one in flight
    load(8'h01); load(8'h02); load(8'h03); load(8'h04); load(8'h05); load(8'h06);
    step();
    step();
    chk("s4_pre_valid", {31'd0, bus.m_valid}, 32'd1);
    chk("s4_pre_data",  {24'd0, bus.m_data},  32'h01);
    flush = 1'b1;
    exp_q.delete(1);                          // 0x02 returning during flush entry
    exp_q.delete(1);                          // 0x03 issued on the flush cycle
    step();
    flush = 1'b0;
    chk("s4_valid_cleared", {31'd0, bus.m_valid},    32'd0);
    chk("s4_busy_flush",    {31'd0, busy},           32'd1);
    chk("s4_rd_en_forced",  {31'd0, bus.fifo_rd_en}, 32'd0);
    step();
    chk("s4_rd_en_wait",    {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("s4_valid_wait",    {31'd0, bus.m_valid},    32'd0);
    step();
    chk("s4_rd_en_resume",  {31'd0, bus.fifo_rd_en}, 32'd1);
    step();
    step();
    chk("s4_next_valid",    {31'd0, bus.m_valid},    32'd1);
    chk("s4_next_data",     {24'd0, bus.m_data},     32'h04);
    wait_drain("s4_drain", 40);

    // Sticky underflow, cleared by flush
    bus.fifo_underflow = 1'b1;
    step();
    bus.fifo_underflow = 1'b0;
    chk("s5_err_set", {31'd0, err_underflow}, 32'd1);
    step();
    step();
    chk("s5_err_held", {31'd0, err_underflow}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("s5_err_clear", {31'd0, err_underflow}, 32'd0);
    step();
    step();
    chk("s5_err_stays_clear", {31'd0, err_underflow}, 32'd0);

    // Fresh reset, then 17 transfers
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) load(8'h80 + 8'(i));
    wait_drain("s6_drain", 80);
`ifdef SYNC_FIFO_READER_STATS_EN
    chk("s6_rd_count_wrap", {28'd0, rd_count}, 32'd1);
`endif

    // Reset in the middle of a stream
    load(8'hC0); load(8'hC1); load(8'hC2); load(8'hC3); load(8'hC4);
    step();
    step();
    bus.fifo_underflow = 1'b1;
    step();
    bus.fifo_underflow = 1'b0;
    chk("s7_pre_valid", {31'd0, bus.m_valid},   32'd1);
    chk("s7_pre_err",   {31'd0, err_underflow}, 32'd1);
    rst       = 1'b1;
    fifo_drop = 1'b1;
    exp_q.delete();
    step();
    chk("s7_rd_en",   {31'd0, bus.fifo_rd_en}, 32'd0);
    chk("s7_m_valid", {31'd0, bus.m_valid},    32'd0);
    chk("s7_m_data",  {24'd0, bus.m_data},     32'd0);
    chk("s7_busy",    {31'd0, busy},           32'd0);
    chk("s7_err",     {31'd0, err_underflow},  32'd0);
`ifdef SYNC_FIFO_READER_STATS_EN
    chk("s7_rd_count", {28'd0, rd_count},      32'd0);
`endif
    fifo_drop = 1'b0;
    rst       = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
